// File: rtl/conv_pkg.sv
// Shared widths, kernel-0 coefficients, memory selects and FSM encoding for conv_engine.
package conv_pkg;
  localparam int IMG_W  = 64;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int ACC_W  = 40;

  // Q4.16 weights, row-major, top-left first.
  localparam logic signed [DATA_W-1:0] K0 [0:8] = '{
    20'h0A89E, 20'h092D5, 20'h06D43,
    20'h01004, 20'hF8F71, 20'hF6E54,
    20'hFA6D7, 20'hFC834, 20'hFAC19
  };
  localparam logic signed [DATA_W-1:0] BIAS = 20'h01310;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    IDLE, CONV_RD, CONV_WR, POOL_RD, POOL_WR, DONE
  } state_e;
endpackage

// File: rtl/conv_mac.sv
// 9-tap signed MAC: accumulator preloaded with bias<<16, result rounded half-up
// to Q4.16 with 20-bit wrap, then ReLU. res_o is valid the cycle after the last tap.
module conv_mac
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [3:0]        tap_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0] res_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d, prod;
  logic [DATA_W-1:0]       rnd;
  logic                    unused_acc;

  always_comb begin
    prod  = ACC_W'($signed(pix_i)) * ACC_W'(K0[tap_i]);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = ACC_W'(BIAS) <<< 16;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
    rnd   = acc_q[35:16] + {{(DATA_W-1){1'b0}}, acc_q[15]};
    res_o = rnd[DATA_W-1] ? '0 : rnd;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign unused_acc = ^{acc_q[ACC_W-1:36], acc_q[14:0]};
endmodule

// File: rtl/conv_engine.sv
// 3x3 conv + bias + ReLU into L0, then 2x2 stride-2 max-pool into L1.
// One memory access per cycle: 11 cycles per L0 pixel, 6 cycles per L1 pixel.
module conv_engine
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel
);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_W*IMG_W-1);
  localparam logic [9:0]        LAST_POOL = 10'(IMG_W*IMG_W/4-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [3:0]        tap_q, tap_d;
  logic [9:0]        ppix_q, ppix_d;
  logic [2:0]        sub_q, sub_d;
  logic              inb_q, inb_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [1:0]        ti, tj;
  logic [6:0]        nr, nc;
  logic              mac_clr, mac_en;
  logic [3:0]        mac_tap;
  logic [DATA_W-1:0] mac_pix, mac_res;

  // Neighbour of the tap being issued; bit 6 set means it lies outside the image.
  always_comb begin
    ti = 2'(tap_q / 4'd3);
    tj = 2'(tap_q % 4'd3);
    nr = {1'b0, pix_q[11:6]} + {5'b0, ti} - 7'd1;
    nc = {1'b0, pix_q[5:0]}  + {5'b0, tj} - 7'd1;
  end

  // Data for tap k arrives while tap_q == k+1, so the MAC runs one tap behind the address.
  assign mac_clr = (state_q == CONV_RD) && (tap_q == 4'd0);
  assign mac_en  = (state_q == CONV_RD) && (tap_q != 4'd0);
  assign mac_tap = tap_q - 4'd1;
  assign mac_pix = inb_q ? idata : '0;

  conv_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .tap_i (mac_tap),
    .pix_i (mac_pix),
    .res_o (mac_res)
  );

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    tap_d    = tap_q;
    ppix_d   = ppix_q;
    sub_d    = sub_q;
    max_d    = max_q;
    inb_d    = ~nr[6] & ~nc[6];
    busy     = 1'b1;
    iaddr    = '0;
    cwr      = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    csel     = CSEL_NONE;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (ready) begin
          state_d = CONV_RD;
          pix_d   = '0;
          tap_d   = '0;
        end
      end
      CONV_RD: begin
        if (tap_q == 4'd9) begin
          state_d = CONV_WR;
        end else begin
          iaddr = {nr[5:0], nc[5:0]};
          tap_d = tap_q + 4'd1;
        end
      end
      CONV_WR: begin
        cwr      = 1'b1;
        csel     = CSEL_L0;
        caddr_wr = pix_q;
        cdata_wr = mac_res;
        tap_d    = '0;
        if (pix_q == LAST_PIX) begin
          state_d = POOL_RD;
          ppix_d  = '0;
          sub_d   = '0;
        end else begin
          state_d = CONV_RD;
          pix_d   = pix_q + 12'd1;
        end
      end
      POOL_RD: begin
        if (sub_q != 3'd4) begin
          crd      = 1'b1;
          csel     = CSEL_L0;
          caddr_rd = {ppix_q[9:5], sub_q[1], ppix_q[4:0], sub_q[0]};
        end
        if (sub_q == 3'd1) begin
          max_d = cdata_rd;
        end else if (sub_q != 3'd0 && $signed(cdata_rd) > $signed(max_q)) begin
          max_d = cdata_rd;
        end
        if (sub_q == 3'd4) state_d = POOL_WR;
        else               sub_d   = sub_q + 3'd1;
      end
      POOL_WR: begin
        cwr      = 1'b1;
        csel     = CSEL_L1;
        caddr_wr = {2'b00, ppix_q};
        cdata_wr = max_q;
        sub_d    = '0;
        if (ppix_q == LAST_POOL) begin
          state_d = DONE;
        end else begin
          state_d = POOL_RD;
          ppix_d  = ppix_q + 10'd1;
        end
      end
      DONE: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      tap_q   <= '0;
      ppix_q  <= '0;
      sub_q   <= '0;
      inb_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      tap_q   <= tap_d;
      ppix_q  <= ppix_d;
      sub_q   <= sub_d;
      inb_q   <= inb_d;
      max_q   <= max_d;
    end
  end
endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: registered ROM/memory models, a golden conv/pool model feeding
// write-order scoreboards, constant spot checks, and a mid-run reset followed by a full run.
module tb_conv_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        busy, cwr, crd;
  logic [11:0] iaddr, caddr_wr, caddr_rd;
  logic [19:0] idata, cdata_wr, cdata_rd;
  logic [2:0]  csel;

  always #5 clk = ~clk;

  conv_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .csel(csel)
  );

  localparam logic [19:0] W [0:8] = '{
    20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
    20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19
  };
  localparam logic [19:0] BIAS_T = 20'h01310;

  typedef struct packed { logic [11:0] addr; logic [19:0] data; } wr_t;

  logic [19:0] rom     [0:4095];
  logic [19:0] l0_mem  [0:4095];
  logic [19:0] l1_mem  [0:1023];
  logic [19:0] gold_l0 [0:4095];
  wr_t exp_l0_q[$];
  wr_t exp_l1_q[$];
  wr_t e;

  int n_checks = 0;
  int n_fail = 0;
  int l0_wr_cnt = 0, l1_wr_cnt = 0, bad_csel = 0, rdwr_overlap = 0, sb_err = 0;
  bit sb_en = 1'b0;

  // Registered image ROM and layer memories: data appears the cycle after the address.
  always @(posedge clk) begin
    idata <= rom[iaddr];
    if (crd) cdata_rd <= (csel == 3'b011) ? l1_mem[caddr_rd[9:0]] : l0_mem[caddr_rd];
    if (cwr && csel == 3'b001) l0_mem[caddr_wr] <= cdata_wr;
    if (cwr && csel == 3'b011) l1_mem[caddr_wr[9:0]] <= cdata_wr;
  end

  // Write monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (cwr && crd) rdwr_overlap++;
    if (cwr) begin
      if (csel == 3'b001) begin
        l0_wr_cnt++;
        if (sb_en) begin
          if (exp_l0_q.size() == 0) sb_err++;
          else begin
            e = exp_l0_q.pop_front();
            if (caddr_wr !== e.addr || cdata_wr !== e.data) begin
              if (sb_err == 0)
                $display("first L0 difference: addr %h data %h, expected addr %h data %h",
                         caddr_wr, cdata_wr, e.addr, e.data);
              sb_err++;
            end
          end
        end
      end else if (csel == 3'b011) begin
        l1_wr_cnt++;
        if (sb_en) begin
          if (exp_l1_q.size() == 0) sb_err++;
          else begin
            e = exp_l1_q.pop_front();
            if (caddr_wr !== e.addr || cdata_wr !== e.data) begin
              if (sb_err == 0)
                $display("first L1 difference: addr %h data %h, expected addr %h data %h",
                         caddr_wr, cdata_wr, e.addr, e.data);
              sb_err++;
            end
          end
        end
      end else begin
        bad_csel++;
      end
    end
  end

  // Image regions: +1.0 block, -1.0 block, random patch, single +1.0 pixel, tiny pixel for rounding.
  task automatic load_image();
    for (int a = 0; a < 4096; a++) rom[a] = 20'h0;
    for (int r = 0; r < 16; r++)  for (int c = 0; c < 16; c++) rom[r*64+c] = 20'h10000;
    for (int r = 16; r < 24; r++) for (int c = 0; c < 16; c++) rom[r*64+c] = 20'hF0000;
    for (int r = 40; r < 48; r++) for (int c = 20; c < 44; c++) rom[r*64+c] = 20'($urandom);
    rom[32*64+32] = 20'h10000;
    rom[50*64+50] = 20'h00001;
  endtask

  task automatic build_gold();
    logic signed [39:0] acc;
    logic [19:0] res, m, v;
    int rr, cc;
    exp_l0_q.delete();
    exp_l1_q.delete();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        acc = 40'($signed(BIAS_T)) * 40'sd65536;
        for (int i = -1; i <= 1; i++) begin
          for (int j = -1; j <= 1; j++) begin
            rr = r + i;
            cc = c + j;
            if (rr >= 0 && rr < 64 && cc >= 0 && cc < 64)
              acc = acc + 40'($signed(rom[rr*64+cc])) * 40'($signed(W[(i+1)*3+(j+1)]));
          end
        end
        res = acc[35:16] + {19'b0, acc[15]};
        if (res[19]) res = 20'h0;
        gold_l0[r*64+c] = res;
        exp_l0_q.push_back({12'(r*64+c), res});
      end
    end
    for (int pr = 0; pr < 32; pr++) begin
      for (int pc = 0; pc < 32; pc++) begin
        m = gold_l0[(2*pr)*64 + 2*pc];
        for (int k = 1; k < 4; k++) begin
          v = gold_l0[(2*pr + k/2)*64 + 2*pc + k%2];
          if ($signed(v) > $signed(m)) m = v;
        end
        exp_l1_q.push_back({12'(pr*32+pc), m});
      end
    end
  endtask

  task automatic test_reset();
    logic [61:0] obs;
    reset = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {busy, cwr, crd, csel, iaddr, caddr_rd, caddr_wr, cdata_wr};
    n_checks++;
    if (obs !== 62'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
  endtask

  task automatic test_start_after_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: got %b want 1", busy);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_conv();
    int cyc = 0;
    while (l0_wr_cnt < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (l0_wr_cnt < 100) begin
      n_fail++;
      $display("FAIL abort_reach_pixel100: got %0d writes want 100", l0_wr_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cwr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy %b cwr %b want 0 0", busy, cwr);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_without_ready: busy %b want 0", busy);
    end
  endtask

  task automatic test_full_run();
    int cyc = 0;
    build_gold();
    l0_wr_cnt = 0; l1_wr_cnt = 0; bad_csel = 0; rdwr_overlap = 0; sb_err = 0;
    sb_en = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start_busy: got %b want 1", busy);
    end
    while (busy !== 1'b0 && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      ready = (cyc >= 500 && cyc < 503);
    end
    ready = 1'b0;
    sb_en = 1'b0;
    n_checks++;
    if (cyc >= 60000) begin
      n_fail++;
      $display("FAIL run_cycles: got %0d want < 60000", cyc);
    end
    n_checks++;
    if (l0_wr_cnt !== 4096 || l1_wr_cnt !== 1024) begin
      n_fail++;
      $display("FAIL write_counts: L0 %0d L1 %0d want 4096 1024", l0_wr_cnt, l1_wr_cnt);
    end
    n_checks++;
    if (bad_csel !== 0 || rdwr_overlap !== 0) begin
      n_fail++;
      $display("FAIL bus_rules: bad csel %0d rd/wr overlap %0d want 0 0", bad_csel, rdwr_overlap);
    end
    n_checks++;
    if (sb_err !== 0 || exp_l0_q.size() !== 0 || exp_l1_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d differences, %0d/%0d expected writes left, want 0",
               sb_err, exp_l0_q.size(), exp_l1_q.size());
    end
  endtask

  task automatic test_l0_points();
    logic [11:0] pa [0:7];
    logic [19:0] pv [0:7];
    pa = '{12'(33*64+33), 12'(32*64+32), 12'(31*64+31), 12'(50*64+50),
           12'(60*64+5), 12'(20*64+8), 12'(0), 12'(10*64+10)};
    pv = '{20'h0BBAE, 20'h00000, 20'h00000, 20'h01310,
           20'h01310, 20'h0416D, gold_l0[0], gold_l0[10*64+10]};
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (l0_mem[pa[k]] !== pv[k]) begin
        n_fail++;
        $display("FAIL l0_point addr %h: got %h want %h", pa[k], l0_mem[pa[k]], pv[k]);
      end
    end
  endtask

  task automatic test_pool();
    logic [19:0] m, v;
    int bad = 0;
    for (int pr = 0; pr < 32; pr++) begin
      for (int pc = 0; pc < 32; pc++) begin
        m = l0_mem[(2*pr)*64 + 2*pc];
        for (int k = 1; k < 4; k++) begin
          v = l0_mem[(2*pr + k/2)*64 + 2*pc + k%2];
          if ($signed(v) > $signed(m)) m = v;
        end
        if (l1_mem[pr*32+pc] !== m) bad++;
      end
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL pool_max_of_l0: %0d L1 words differ, want 0", bad);
    end
    n_checks++;
    if (l1_mem[31*32+31] !== 20'h01310) begin
      n_fail++;
      $display("FAIL pool_zero_area: got %h want 01310", l1_mem[31*32+31]);
    end
    n_checks++;
    if (l1_mem[10*32+4] !== 20'h0416D) begin
      n_fail++;
      $display("FAIL pool_neg_block: got %h want 0416D", l1_mem[10*32+4]);
    end
  endtask

  initial begin
    load_image();
    test_reset();
    test_start_after_reset();
    test_reset_mid_conv();
    test_full_run();
    test_l0_points();
    test_pool();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
